bayes_infer_master: RTL and testbench

AXI-Lite initiator that drives the Bayesian-machine control peripheral from the host side. It accepts one inference command (four observations plus stochastic/log mode) and writes only the changed configuration registers. It then reads the result register and returns the four 8-bit posterior bytes on a valid/ready result port; it sits between a local sequencer/DMA and the peripheral's AXI-Lite slave.

---
 rtl/bayes_infer_master_if.sv | 47 ++++
 rtl/bayes_infer_master.sv | 268 ++++++++++++++++++++++++++
 tb/tb_bayes_infer_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bayes_infer_master_if.sv
// Bus bundle for bayes_infer_master: command port, result port and the
// AXI-Lite initiator channels. The master modport is the block's view,
// the slave modport is the environment (sequencer plus peripheral).
interface bayes_infer_master_if;
   // Command and result ports
   logic        cmd_valid;
   logic        cmd_ready;
   logic [35:0] cmd_obs;
   logic        cmd_stoch_log;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_err;
   // AXI-Lite write channels
   logic [31:0] aw_addr;
   logic        aw_valid;
   logic        aw_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_valid;
   logic        w_ready;
   logic [1:0]  b_resp;
   logic        b_valid;
   logic        b_ready;
   // AXI-Lite read channels
   logic [31:0] ar_addr;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_valid;
   logic        r_ready;

   modport master (
      input  cmd_valid, cmd_obs, cmd_stoch_log, res_ready,
      input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid,
      output cmd_ready, res_valid, res_data, res_err,
      output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready
   );

   modport slave (
      output cmd_valid, cmd_obs, cmd_stoch_log, res_ready,
      output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid,
      input  cmd_ready, res_valid, res_data, res_err,
      input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready
   );
endinterface

// File: rtl/bayes_infer_master.sv
// AXI-Lite initiator for the Bayesian-machine control peripheral.
// Takes one inference command, writes only configuration registers whose
// shadow copy is stale or invalid, then reads the result register and
// presents the four posterior bytes on the result port.
// Optional per-phase watchdog: define BAYES_MASTER_TIMEOUT_EN.
module bayes_infer_master #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bayes_infer_master_if.master bus_io
);

   localparam logic [31:0] RegBase = BASE_ADDR + 32'h2000;
   localparam int unsigned NumEntries = 5;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdResp,
      StResult
   } state_e;

   state_e      state_q, state_d;
   logic [35:0] obs_q, obs_d;
   logic        log_q, log_d;
   logic [2:0]  idx_q, idx_d;
   logic [8:0]  shadow_q [NumEntries];
   logic [8:0]  shadow_d [NumEntries];
   logic [4:0]  shadow_vld_q, shadow_vld_d;
   logic        aw_valid_q, aw_valid_d;
   logic        w_valid_q, w_valid_d;
   logic        ar_valid_q, ar_valid_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic [31:0] w_data_q, w_data_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic        b_got_q, b_got_d;
   logic [1:0]  b_resp_q, b_resp_d;
   logic [31:0] res_data_q, res_data_d;
   logic        res_err_q, res_err_d;
   logic        cmd_ready_q, b_ready_q, r_ready_q, res_valid_q;

   logic [8:0]  entry_val;
   logic        entry_dirty;
   logic [31:0] entry_addr;
   logic [1:0]  wr_resp;
   logic        tmo;

   // Current entry: value, target address and whether it needs a write
   always_comb begin
      entry_val = 9'd0;
      case (idx_q)
         3'd0:    entry_val = obs_q[8:0];
         3'd1:    entry_val = obs_q[17:9];
         3'd2:    entry_val = obs_q[26:18];
         3'd3:    entry_val = obs_q[35:27];
         3'd4:    entry_val = {8'd0, log_q};
         default: entry_val = 9'd0;
      endcase
      entry_dirty = 1'b0;
      if (idx_q < 3'd5) begin
         entry_dirty = !shadow_vld_q[idx_q] || (shadow_q[idx_q] != entry_val);
      end
      // Entries 0..4 live in registers 3..7
      entry_addr = RegBase + {27'd0, idx_q + 3'd3, 2'b00};
   end

`ifdef BAYES_MASTER_TIMEOUT_EN
   logic [31:0] tmo_cnt_q;
   logic        in_phase;

   assign in_phase = state_q inside {StWrReq, StWrResp, StRdReq, StRdResp};
   assign tmo      = in_phase && (tmo_cnt_q == TIMEOUT_CYCLES - 1);

   // Watchdog restarts on every state change, so each bus phase gets its own budget
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else if (state_d != state_q) begin
         tmo_cnt_q <= '0;
      end else if (in_phase) begin
         tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end
   end
`else
   logic unused_tmo_cfg;

   assign tmo            = 1'b0;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

   // Sequencing FSM: next state, bus channel state and shadow updates
   always_comb begin
      state_d      = state_q;
      obs_d        = obs_q;
      log_d        = log_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      aw_valid_d   = aw_valid_q;
      w_valid_d    = w_valid_q;
      ar_valid_d   = ar_valid_q;
      aw_addr_d    = aw_addr_q;
      w_data_d     = w_data_q;
      ar_addr_d    = ar_addr_q;
      b_got_d      = b_got_q;
      b_resp_d     = b_resp_q;
      res_data_d   = res_data_q;
      res_err_d    = res_err_q;
      wr_resp      = 2'b00;

      unique case (state_q)
         StIdle: begin
            if (bus_io.cmd_valid && cmd_ready_q) begin
               obs_d     = bus_io.cmd_obs;
               log_d     = bus_io.cmd_stoch_log;
               res_err_d = 1'b0;
               idx_d     = 3'd0;
               state_d   = StSelect;
            end
         end
         StSelect: begin
            if (entry_dirty) begin
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               aw_addr_d  = entry_addr;
               w_data_d   = {23'd0, entry_val};
               b_got_d    = 1'b0;
               state_d    = StWrReq;
            end else if (idx_q >= 3'd4) begin
               // Last entry clean (or all written): go straight to the read
               ar_valid_d = 1'b1;
               ar_addr_d  = RegBase;
               state_d    = StRdReq;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         StWrReq: begin
            if (aw_valid_q && bus_io.aw_ready) aw_valid_d = 1'b0;
            if (w_valid_q && bus_io.w_ready) w_valid_d = 1'b0;
            // b_ready is high here, so an early response must be kept
            if (bus_io.b_valid) begin
               b_got_d  = 1'b1;
               b_resp_d = bus_io.b_resp;
            end
            if (!aw_valid_d && !w_valid_d) state_d = StWrResp;
         end
         StWrResp: begin
            if (b_got_q || bus_io.b_valid) begin
               wr_resp = b_got_q ? b_resp_q : bus_io.b_resp;
               if (wr_resp == 2'b00) begin
                  shadow_d[idx_q]     = entry_val;
                  shadow_vld_d[idx_q] = 1'b1;
               end else begin
                  res_err_d           = 1'b1;
                  shadow_vld_d[idx_q] = 1'b0;
               end
               b_got_d = 1'b0;
               idx_d   = idx_q + 3'd1;
               state_d = StSelect;
            end
         end
         StRdReq: begin
            if (ar_valid_q && bus_io.ar_ready) begin
               ar_valid_d = 1'b0;
               state_d    = StRdResp;
            end
         end
         StRdResp: begin
            if (bus_io.r_valid) begin
               res_data_d = bus_io.r_data;
               if (bus_io.r_resp != 2'b00) res_err_d = 1'b1;
               state_d = StResult;
            end
         end
         StResult: begin
            if (res_valid_q && bus_io.res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Watchdog abandons the phase; peripheral state is unknown afterwards
      if (tmo) begin
         aw_valid_d   = 1'b0;
         w_valid_d    = 1'b0;
         ar_valid_d   = 1'b0;
         b_got_d      = 1'b0;
         res_err_d    = 1'b1;
         shadow_vld_d = '0;
         res_data_d   = '0;
         state_d      = StResult;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         obs_q        <= '0;
         log_q        <= 1'b0;
         idx_q        <= '0;
         shadow_q     <= '{default: '0};
         shadow_vld_q <= '0;
         aw_valid_q   <= 1'b0;
         w_valid_q    <= 1'b0;
         ar_valid_q   <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         ar_addr_q    <= '0;
         b_got_q      <= 1'b0;
         b_resp_q     <= '0;
         res_data_q   <= '0;
         res_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         obs_q        <= obs_d;
         log_q        <= log_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         shadow_vld_q <= shadow_vld_d;
         aw_valid_q   <= aw_valid_d;
         w_valid_q    <= w_valid_d;
         ar_valid_q   <= ar_valid_d;
         aw_addr_q    <= aw_addr_d;
         w_data_q     <= w_data_d;
         ar_addr_q    <= ar_addr_d;
         b_got_q      <= b_got_d;
         b_resp_q     <= b_resp_d;
         res_data_q   <= res_data_d;
         res_err_q    <= res_err_d;
      end
   end

   // Registered readies/valids so every output is zero while in reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready_q <= 1'b0;
         b_ready_q   <= 1'b0;
         r_ready_q   <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         cmd_ready_q <= (state_d == StIdle);
         b_ready_q   <= state_d inside {StWrReq, StWrResp};
         r_ready_q   <= state_d inside {StRdReq, StRdResp};
         res_valid_q <= (state_d == StResult);
      end
   end

   assign bus_io.cmd_ready = cmd_ready_q;
   assign bus_io.res_valid = res_valid_q;
   assign bus_io.res_data  = res_data_q;
   assign bus_io.res_err   = res_err_q;
   assign bus_io.aw_addr   = aw_addr_q;
   assign bus_io.aw_valid  = aw_valid_q;
   assign bus_io.w_data    = w_data_q;
   assign bus_io.w_strb    = 4'hF;
   assign bus_io.w_valid   = w_valid_q;
   assign bus_io.b_ready   = b_ready_q;
   assign bus_io.ar_addr   = ar_addr_q;
   assign bus_io.ar_valid  = ar_valid_q;
   assign bus_io.r_ready   = r_ready_q;

endmodule

// File: tb/tb_bayes_infer_master.sv
// Scoreboard bench for bayes_infer_master: stimulus pushes expected writes
// and results from a shadow-register model; slave and result processes pop
// and compare. Watchdog scenario runs when BAYES_MASTER_TIMEOUT_EN is set.
module tb_bayes_infer_master;

   localparam logic [31:0] Base   = 32'h0000_0000;
   localparam logic [31:0] RdAddr = Base + 32'h2000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bayes_infer_master_if bus ();

   bayes_infer_master #(
      .BASE_ADDR      (Base),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   int          checks = 0;
   int          failures = 0;
   wr_t         exp_wr[$];
   res_t        exp_res[$];
   logic [31:0] aw_q[$];
   logic [31:0] w_q[$];
   int          dmode = 0;      // 0 random delays, 1 zero, 2 aw 3 cycles after w
   int          rr_mode = 1;    // 0 random res_ready, 1 always, 2 held low
   logic [31:0] err_addr = '1;
   logic [31:0] rd_val = '0;
   logic        rd_err = 1'b0;
   logic        ar_block = 1'b0;
   logic [8:0]  m_sh[5];
   logic        m_vld[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: got timeout expected completion", name);
   endtask

   function automatic int dly(input bit is_aw);
      if (dmode == 0) return int'($urandom_range(0, 3));
      if (dmode == 2) return is_aw ? 3 : 0;
      return 0;
   endfunction

   // AW channel slave
   initial begin
      logic [31:0] a;
      int d;
      bus.aw_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.aw_ready = 1'b0;
         if (bus.aw_valid) begin
            check("no_overlap", bus.ar_valid, 1'b0);
            a = bus.aw_addr;
            d = dly(1'b1);
            repeat (d) @(negedge clk);
            if (bus.aw_valid) begin
               bus.aw_ready = 1'b1;
               @(negedge clk);
               bus.aw_ready = 1'b0;
               aw_q.push_back(a);
            end
         end
      end
   end

   // W channel slave
   initial begin
      logic [31:0] wd;
      int d;
      bus.w_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.w_ready = 1'b0;
         if (bus.w_valid) begin
            check("w_strb", bus.w_strb, 4'hF);
            wd = bus.w_data;
            d = dly(1'b0);
            repeat (d) @(negedge clk);
            if (bus.w_valid) begin
               bus.w_ready = 1'b1;
               @(negedge clk);
               bus.w_ready = 1'b0;
               w_q.push_back(wd);
            end
         end
      end
   end

   // B channel: scoreboard the completed write, then pulse the response
   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      wr_t e;
      int d;
      bus.b_valid = 1'b0;
      bus.b_resp  = 2'b00;
      forever begin
         @(negedge clk);
         bus.b_valid = 1'b0;
         if (aw_q.size() > 0 && w_q.size() > 0) begin
            a  = aw_q.pop_front();
            wd = w_q.pop_front();
            if (exp_wr.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected none", a, wd);
            end else begin
               e = exp_wr.pop_front();
               check("wr_addr", a, e.addr);
               check("wr_data", wd, e.data);
            end
            d = dly(1'b0) + (dmode == 0 ? int'($urandom_range(0, 2)) : 0);
            repeat (d) @(negedge clk);
            bus.b_resp  = (a == err_addr) ? 2'd2 : 2'd0;
            bus.b_valid = 1'b1;
         end
      end
   end

   // AR/R channels
   initial begin
      int d;
      int n;
      bus.ar_ready = 1'b0;
      bus.r_valid  = 1'b0;
      bus.r_data   = '0;
      bus.r_resp   = 2'b00;
      forever begin
         @(negedge clk);
         bus.r_valid = 1'b0;
         if (bus.ar_valid && !ar_block) begin
            check("rd_addr", bus.ar_addr, RdAddr);
            check("writes_before_read", exp_wr.size(), 0);
            d = dly(1'b0);
            repeat (d) @(negedge clk);
            bus.ar_ready = 1'b1;
            @(negedge clk);
            bus.ar_ready = 1'b0;
            d = dly(1'b0);
            repeat (d) @(negedge clk);
            n = 0;
            while (!bus.r_ready && n < 50) begin
               @(negedge clk);
               n++;
            end
            if (n >= 50) fail_now("r_ready_wait");
            bus.r_data  = rd_val;
            bus.r_resp  = rd_err ? 2'd2 : 2'd0;
            bus.r_valid = 1'b1;
         end
      end
   end

   // Result consumer and monitor
   initial begin
      res_t r;
      bus.res_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rr_mode)
            0:       bus.res_ready = 1'($urandom_range(0, 1));
            1:       bus.res_ready = 1'b1;
            default: bus.res_ready = 1'b0;
         endcase
         if (bus.res_valid && bus.res_ready) begin
            if (exp_res.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
            end else begin
               r = exp_res.pop_front();
               check("res_data", bus.res_data, r.data);
               check("res_err", bus.res_err, r.err);
            end
         end else if (bus.res_valid && exp_res.size() > 0) begin
            check("res_data_stable", bus.res_data, exp_res[0].data);
            check("res_err_stable", bus.res_err, exp_res[0].err);
         end
      end
   end

   // Model one command and offer it to the DUT
   task automatic issue(input logic [35:0] obs, input logic lg, input logic [31:0] rv,
                        input logic re);
      logic [8:0] v[5];
      logic       err;
      wr_t        w;
      res_t       r;
      int         n;
      err = 1'b0;
      for (int i = 0; i < 4; i++) v[i] = obs[i*9 +: 9];
      v[4] = {8'd0, lg};
      for (int i = 0; i < 5; i++) begin
         if (!m_vld[i] || m_sh[i] != v[i]) begin
            w.addr = Base + 32'h2000 + 32'(4 * (i + 3));
            w.data = {23'd0, v[i]};
            exp_wr.push_back(w);
            if (w.addr == err_addr) begin
               err      = 1'b1;
               m_vld[i] = 1'b0;
            end else begin
               m_sh[i]  = v[i];
               m_vld[i] = 1'b1;
            end
         end
      end
      rd_val = rv;
      rd_err = re;
      r.data = rv;
      r.err  = err | re;
      if (ar_block) begin
         r.data = '0;
         r.err  = 1'b1;
         for (int i = 0; i < 5; i++) m_vld[i] = 1'b0;
      end
      exp_res.push_back(r);
      @(negedge clk);
      bus.cmd_valid     = 1'b1;
      bus.cmd_obs       = obs;
      bus.cmd_stoch_log = lg;
      n = 0;
      while (!bus.cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("cmd_accept");
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_res.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) fail_now("result_wait");
      repeat (2) @(negedge clk);
      check("idle_outputs", {bus.cmd_ready, bus.res_valid, bus.aw_valid, bus.w_valid,
                             bus.ar_valid}, 5'b10000);
   endtask

   function automatic logic [35:0] pack(input logic [8:0] o1, input logic [8:0] o2,
                                        input logic [8:0] o3, input logic [8:0] o4);
      return {o4, o3, o2, o1};
   endfunction

   initial begin
      logic [35:0] obs;
      int n;
      bus.cmd_valid     = 1'b0;
      bus.cmd_obs       = '0;
      bus.cmd_stoch_log = 1'b0;
      for (int i = 0; i < 5; i++) begin
         m_vld[i] = 1'b0;
         m_sh[i]  = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {bus.cmd_ready, bus.res_valid, bus.res_err, bus.aw_valid,
                           bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready}, 8'h00);
      check("reset_res_data", bus.res_data, 32'h0);
      check("reset_addrs", {bus.aw_addr, bus.ar_addr}, 64'h0);
      check("reset_w_data", bus.w_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // First command: all five registers written
      obs = pack(9'd1, 9'd2, 9'd3, 9'd4);
      issue(obs, 1'b1, 32'h1122_3344, 1'b0);
      wait_done();

      // Identical command: read only, bounded latency
      dmode = 1;
      issue(obs, 1'b1, 32'hA5A5_0F0F, 1'b0);
      n = 0;
      while (!bus.res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("clean_latency_le8", (n <= 8), 1'b1);
      wait_done();

      // Only O3 changes
      dmode = 0;
      obs = pack(9'd1, 9'd2, 9'h1FF, 9'd4);
      issue(obs, 1'b1, 32'h0102_0304, 1'b0);
      wait_done();

      // Error on the O2 write, then resend the same command
      err_addr = Base + 32'h2010;
      obs = pack(9'd1, 9'd77, 9'h1FF, 9'd4);
      issue(obs, 1'b1, 32'hDEAD_BEEF, 1'b0);
      wait_done();
      err_addr = '1;
      issue(obs, 1'b1, 32'hCAFE_F00D, 1'b0);
      wait_done();

      // Slow AW, pulsed B, result held off for 10 cycles
      dmode   = 2;
      rr_mode = 2;
      obs = pack(9'd10, 9'd20, 9'd30, 9'd40);
      issue(obs, 1'b0, 32'h8090_A0B0, 1'b1);
      n = 0;
      while (!bus.res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) fail_now("hold_res_valid");
      repeat (10) @(negedge clk);
      rr_mode = 1;
      wait_done();

      // Randomized commands
      dmode   = 0;
      rr_mode = 0;
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) obs[i*9 +: 9] = 9'($urandom_range(0, 511));
         end
         err_addr = ($urandom_range(0, 3) == 0) ?
                    (Base + 32'h200C + 32'(4 * $urandom_range(0, 4))) : '1;
         issue(obs, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0));
         wait_done();
      end
      err_addr = '1;
      rr_mode  = 1;

`ifdef BAYES_MASTER_TIMEOUT_EN
      // Read address never accepted: watchdog ends the command
      ar_block = 1'b1;
      issue(obs, 1'b0, 32'h1234_5678, 1'b0);
      wait_done();
      ar_block = 1'b0;
      issue(obs, 1'b0, 32'h8765_4321, 1'b0);
      wait_done();
`endif

      // Reset in the middle of a write
      dmode = 2;
      obs = pack(9'd100, 9'd101, 9'd102, 9'd103);
      issue(obs, 1'b1, 32'h0, 1'b0);
      n = 0;
      while (!bus.aw_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wr_req_reached", bus.aw_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_ctrl", {bus.cmd_ready, bus.res_valid, bus.res_err, bus.aw_valid,
                                 bus.w_valid, bus.b_ready, bus.ar_valid, bus.r_ready}, 8'h00);
      check("async_reset_aw_addr", bus.aw_addr, 32'h0);
      check("async_reset_w_data", bus.w_data, 32'h0);
      repeat (10) @(negedge clk);
      exp_wr.delete();
      exp_res.delete();
      aw_q.delete();
      w_q.delete();
      for (int i = 0; i < 5; i++) m_vld[i] = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // After reset every register is written again
      dmode = 0;
      issue(obs, 1'b1, 32'h5566_7788, 1'b0);
      wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

endmodule
